// File: rtl/matrix_scheduler_pkg.sv
// matrix_scheduler_pkg: shared slice macros, pointer width and drop counter width for the scheduler.
`define MS_ROW(v, i, n) v[(i)*(n) +: (n)]
`define MS_WORD(v, i, o) v[(i)*(o) +: (o)]
package matrix_scheduler_pkg;
  localparam int M_DEF = 8;
  localparam int N_DEF = 8;
  localparam int O_DEF = 8;
  localparam int PTR_W = $clog2(M_DEF);
  localparam int DROP_W = 16;
endpackage

// File: rtl/matrix_scheduler_if.sv
// matrix_scheduler_if: RX/TX FIFO side signals of the scheduler; drop_cnt exists only with MATRIX_SCHED_DROP_EN.
interface matrix_scheduler_if #(parameter int m = 8, parameter int n = 8, parameter int o = 8);
  import matrix_scheduler_pkg::*;
  logic [m*o-1:0] rx;
  logic [m-1:0] rx_rdy, rx_pop;
  logic [m*n-1:0] lut;
  logic [n-1:0] tx_full, tx_afull, tx_cke;
  logic [o-1:0] tx;
  logic [$clog2(m)-1:0] grant;
`ifdef MATRIX_SCHED_DROP_EN
  logic [DROP_W-1:0] drop_cnt;
  modport master(input rx, rx_rdy, lut, tx_full, tx_afull, output rx_pop, tx, tx_cke, grant, drop_cnt);
  modport slave(output rx, rx_rdy, lut, tx_full, tx_afull, input rx_pop, tx, tx_cke, grant, drop_cnt);
`else
  modport master(input rx, rx_rdy, lut, tx_full, tx_afull, output rx_pop, tx, tx_cke, grant);
  modport slave(output rx, rx_rdy, lut, tx_full, tx_afull, input rx_pop, tx, tx_cke, grant);
`endif
endinterface

// File: rtl/matrix_scheduler_rr_pick.sv
// matrix_scheduler_rr_pick: round-robin pick of the first set request at or after ptr (doubled-vector encoder).
module matrix_scheduler_rr_pick #(
  parameter int m = 8,
  localparam int pw = $clog2(m)
) (
  input  logic [m-1:0]  req,
  input  logic [pw-1:0] ptr,
  output logic [pw-1:0] idx,
  output logic          found
);
  logic [m-1:0] rot;
  logic [pw:0] sum;
  always_comb begin
    rot = m'({req, req} >> ptr);
    sum = '0;
    for (int k = m - 1; k >= 0; k--)
      if (rot[k]) sum = {1'b0, ptr} + (pw+1)'(k);
    idx = sum >= (pw+1)'(m) ? pw'(sum - (pw+1)'(m)) : sum[pw-1:0];
    found = |req;
  end
endmodule

// File: rtl/matrix_scheduler.sv
// matrix_scheduler: work-conserving round-robin RX->TX FIFO scheduler with LUT broadcast.
// MATRIX_SCHED_DROP_EN: serve blocked inputs anyway, writing only writable destinations and counting drops.
module matrix_scheduler import matrix_scheduler_pkg::*; #(
  parameter int m = 8,
  parameter int n = 8,
  parameter int o = 8
) (
  input logic clk,
  input logic rst_n,
  matrix_scheduler_if.master bus
);
  localparam int pw = $clog2(m);
`ifdef MATRIX_SCHED_DROP_EN
  localparam bit drop = 1'b1;
`else
  localparam bit drop = 1'b0;
`endif
  logic [n-1:0] wr, row_w;
  logic [m-1:0] req;
  logic [pw-1:0] ptr, w;
  logic found;
  // a write issued this cycle into an almost-full FIFO is not yet visible in tx_full
  always_comb begin
    wr = ~bus.tx_full & ~(bus.tx_afull & bus.tx_cke);
    req = '0;
    for (int i = 0; i < m; i++)
      req[i] = bus.rx_rdy[i] & ~bus.rx_pop[i] & (drop | ~|(`MS_ROW(bus.lut, i, n) & ~wr));
    row_w = `MS_ROW(bus.lut, w, n);
  end
  matrix_scheduler_rr_pick #(.m(m)) u_pick (.req(req), .ptr(ptr), .idx(w), .found(found));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rx_pop <= '0;
      bus.tx_cke <= '0;
      bus.tx <= '0;
      bus.grant <= '0;
      ptr <= '0;
    end else begin
      bus.rx_pop <= found ? m'(1) << w : '0;
      bus.tx_cke <= found ? row_w & wr : '0;
      if (found) begin
        bus.tx <= `MS_WORD(bus.rx, w, o);
        bus.grant <= w;
        ptr <= w == pw'(m - 1) ? '0 : w + 1'b1;
      end
    end
`ifdef MATRIX_SCHED_DROP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.drop_cnt <= '0;
    else if (found && |(row_w & ~wr) && ~&bus.drop_cnt) bus.drop_cnt <= bus.drop_cnt + 1'b1;
`endif
endmodule
